// File: rtl/addsub_serial_if.sv
// addsub_serial_if -- operand/result handshake bundle for addsub_serial (rev 1.0)
`default_nettype none

interface addsub_serial_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, A, B, op_sub, out_ready,
      input  in_ready, out_valid, result, cout, overflow, zero
   );

   modport slave (
      input  in_valid, A, B, op_sub, out_ready,
      output in_ready, out_valid, result, cout, overflow, zero
   );
endinterface

`default_nettype wire

// File: rtl/addsub_serial.sv
// addsub_serial -- digit-serial add/subtract, DIGIT bits per cycle, LSB slice first (rev 1.0)
`default_nettype none

module addsub_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   addsub_serial_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int OW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic             sub_reg;
   logic             carry;
   logic [CW-1:0]    count;
   logic             cout_reg;
   logic             ovf_reg;
   logic             zero_reg;

   logic [OW-1:0]    offset;
   logic             last;
   logic [DIGIT-1:0] a_slice;
   logic [DIGIT-1:0] b_slice;
   logic [DIGIT:0]   slice_full;
   logic [DIGIT-1:0] slice;
   logic             carry_out;
   logic [WIDTH-1:0] res_next;
   logic             ovf_next;

   assign offset  = OW'(int'(count) * DIGIT);
   assign last    = (count == CW'(N - 1));
   assign a_slice = a_reg[offset +: DIGIT];
   assign b_slice = b_reg[offset +: DIGIT];

   // The extra top bit of the (DIGIT+1)-bit slice value is the carry, or for
   // subtraction the sign of the slice difference, i.e. the borrow out.
   always_comb begin
      slice_full = '0;
      if (sub_reg) begin
         slice_full = {1'b0, a_slice} - {1'b0, b_slice} - {{DIGIT{1'b0}}, carry};
      end else begin
         slice_full = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, carry};
      end
      carry_out = slice_full[DIGIT];
      slice     = slice_full[DIGIT-1:0];

      res_next                  = res_reg;
      res_next[offset +: DIGIT] = slice;

      if (sub_reg) begin
         ovf_next = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (slice[DIGIT-1] != a_reg[WIDTH-1]);
      end else begin
         ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (slice[DIGIT-1] != a_reg[WIDTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid) state_next = RUN;
         RUN:     if (last) state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         sub_reg  <= 1'b0;
         res_reg  <= '0;
         carry    <= 1'b0;
         count    <= '0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
         zero_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg   <= bus.A;
                  b_reg   <= bus.B;
                  sub_reg <= bus.op_sub;
                  res_reg <= '0;
                  carry   <= 1'b0;
                  count   <= '0;
               end
            end
            RUN: begin
               res_reg <= res_next;
               carry   <= carry_out;
               count   <= last ? '0 : count + 1'b1;
               if (last) begin
                  cout_reg <= carry_out;
                  ovf_reg  <= ovf_next;
                  zero_reg <= (res_next == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = res_reg;
   assign bus.cout      = cout_reg;
   assign bus.overflow  = ovf_reg;
   assign bus.zero      = zero_reg;
endmodule

`default_nettype wire

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial -- checks addsub_serial at DIGIT = 1, 4, 8 and 32 against a plain-arithmetic model (rev 1.0)
`default_nettype none

module tb_addsub_serial;
   localparam int W  = 32;
   localparam int NI = 4;
   localparam int DIGITS [NI] = '{1, 4, 8, 32};

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid_v  [NI];
   logic [W-1:0]  a_v         [NI];
   logic [W-1:0]  b_v         [NI];
   logic          sub_v       [NI];
   logic          out_ready_v [NI];
   logic          in_ready_v  [NI];
   logic          out_valid_v [NI];
   logic [W-1:0]  res_v       [NI];
   logic          cout_v      [NI];
   logic          ovf_v       [NI];
   logic          zero_v      [NI];

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         addsub_serial_if #(.WIDTH(W)) bus ();
         assign bus.in_valid    = in_valid_v[gi];
         assign bus.A           = a_v[gi];
         assign bus.B           = b_v[gi];
         assign bus.op_sub      = sub_v[gi];
         assign bus.out_ready   = out_ready_v[gi];
         assign in_ready_v[gi]  = bus.in_ready;
         assign out_valid_v[gi] = bus.out_valid;
         assign res_v[gi]       = bus.result;
         assign cout_v[gi]      = bus.cout;
         assign ovf_v[gi]       = bus.overflow;
         assign zero_v[gi]      = bus.zero;

         addsub_serial #(.WIDTH(W), .DIGIT(DIGITS[gi])) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus.slave)
         );
      end
   endgenerate

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic; overflow means the true signed result
   // does not fit in WIDTH bits.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 output logic [W-1:0] r, output logic c, output logic o,
                                 output logic z);
      longint sa, sb, sr;
      sa = $signed(a);
      sb = $signed(b);
      if (sub) begin
         r  = a - b;
         c  = (a < b);
         sr = sa - sb;
      end else begin
         r  = a + b;
         c  = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
         sr = sa + sb;
      end
      o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      z = (r == '0);
   endfunction

   // Starts at a falling edge with the instance idle; returns at a falling edge with it idle again.
   task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, output logic [W-1:0] r, output logic c,
                         output logic o, output logic z, output int lat);
      string tag;
      tag = $sformatf("d%0d", DIGITS[idx]);
      check({"accept_ready_", tag}, in_ready_v[idx], 1'b1);
      a_v[idx] = a;
      b_v[idx] = b;
      sub_v[idx] = sub;
      in_valid_v[idx] = 1'b1;
      @(negedge clk);
      in_valid_v[idx] = 1'b0;
      a_v[idx] = $urandom;
      b_v[idx] = $urandom;
      sub_v[idx] = ~sub;
      out_ready_v[idx] = 1'b1;
      check({"run_busy_", tag}, in_ready_v[idx], 1'b0);
      lat = 0;
      while (!out_valid_v[idx] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 200) check({"timeout_", tag}, 64'd0, 64'd1);
      r = res_v[idx];
      c = cout_v[idx];
      o = ovf_v[idx];
      z = zero_v[idx];
      @(negedge clk);
      out_ready_v[idx] = 1'b0;
      check({"idle_after_", tag}, in_ready_v[idx], 1'b1);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] r;
      logic         c;
      logic         o;
      logic         z;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [W-1:0] r, er, ra, rb;
      logic c, o, z, ec, eo, ez, rs;
      int lat;

      tbl[0] = '{32'd5,        32'd3,        1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{32'd3,        32'd5,        1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{32'h80000000, 32'd1,        1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{32'd7,        32'd9,        1'b0, 32'd16,       1'b0, 1'b0, 1'b0};
      tbl[5] = '{32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};

      for (int i = 0; i < NI; i++) begin
         in_valid_v[i] = 1'b0;
         a_v[i] = '0;
         b_v[i] = '0;
         sub_v[i] = 1'b0;
         out_ready_v[i] = 1'b0;
      end

      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check("rst_out_valid", out_valid_v[i], 1'b0);
         check("rst_result", res_v[i], '0);
         check("rst_flags", {cout_v[i], ovf_v[i], zero_v[i]}, 3'b000);
      end
      reset_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NI; i++) check("rst_in_ready", in_ready_v[i], 1'b1);

      // Directed vectors on every digit size; latency must be WIDTH/DIGIT.
      for (int idx = 0; idx < NI; idx++) begin
         for (int v = 0; v < 7; v++) begin
            run_op(idx, tbl[v].a, tbl[v].b, tbl[v].sub, r, c, o, z, lat);
            check($sformatf("vec%0d_result_d%0d", v, DIGITS[idx]), r, tbl[v].r);
            check($sformatf("vec%0d_cout_d%0d", v, DIGITS[idx]), c, tbl[v].c);
            check($sformatf("vec%0d_ovf_d%0d", v, DIGITS[idx]), o, tbl[v].o);
            check($sformatf("vec%0d_zero_d%0d", v, DIGITS[idx]), z, tbl[v].z);
            check($sformatf("vec%0d_latency_d%0d", v, DIGITS[idx]), lat, W / DIGITS[idx]);
         end
      end

      // Result held in DONE while inputs churn and the consumer stalls.
      a_v[2] = 32'd5;
      b_v[2] = 32'd3;
      sub_v[2] = 1'b1;
      in_valid_v[2] = 1'b1;
      @(negedge clk);
      in_valid_v[2] = 1'b0;
      lat = 0;
      while (!out_valid_v[2] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("hold_latency", lat, 4);
      for (int k = 0; k < 5; k++) begin
         check("hold_out_valid", out_valid_v[2], 1'b1);
         check("hold_in_ready", in_ready_v[2], 1'b0);
         check("hold_result", res_v[2], 32'd2);
         check("hold_flags", {cout_v[2], ovf_v[2], zero_v[2]}, 3'b000);
         in_valid_v[2] = 1'($urandom);
         a_v[2] = $urandom;
         b_v[2] = $urandom;
         sub_v[2] = 1'($urandom);
         @(negedge clk);
      end
      check("hold_final_result", res_v[2], 32'd2);
      in_valid_v[2] = 1'b0;
      out_ready_v[2] = 1'b1;
      @(negedge clk);
      out_ready_v[2] = 1'b0;
      check("release_out_valid", out_valid_v[2], 1'b0);
      check("release_in_ready", in_ready_v[2], 1'b1);
      @(negedge clk);
      check("release_stays_idle", in_ready_v[2], 1'b1);

      // Reset for one edge in the middle of RUN aborts the operation.
      a_v[2] = 32'hFFFFFFFF;
      b_v[2] = 32'd1;
      sub_v[2] = 1'b0;
      in_valid_v[2] = 1'b1;
      @(negedge clk);
      in_valid_v[2] = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("abort_out_valid", out_valid_v[2], 1'b0);
      check("abort_in_ready", in_ready_v[2], 1'b1);
      check("abort_result", res_v[2], '0);
      check("abort_flags", {cout_v[2], ovf_v[2], zero_v[2]}, 3'b000);
      repeat (5) begin
         @(negedge clk);
         check("abort_no_result", out_valid_v[2], 1'b0);
      end
      run_op(2, 32'd7, 32'd9, 1'b0, r, c, o, z, lat);
      check("after_abort_result", r, 32'd16);
      check("after_abort_cout", c, 1'b0);

      // Randomized regression against the reference model.
      for (int idx = 0; idx < NI; idx++) begin
         for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            case ($urandom_range(0, 3))
               0: ;
               1: rb = ra;
               2: begin
                  ra = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
                  rb = 32'($urandom_range(0, 3));
               end
               default: rb = 32'($urandom_range(0, 255));
            endcase
            model(ra, rb, rs, er, ec, eo, ez);
            run_op(idx, ra, rb, rs, r, c, o, z, lat);
            check($sformatf("rnd_result_d%0d", DIGITS[idx]), r, er);
            check($sformatf("rnd_cout_d%0d", DIGITS[idx]), c, ec);
            check($sformatf("rnd_ovf_d%0d", DIGITS[idx]), o, eo);
            check($sformatf("rnd_zero_d%0d", DIGITS[idx]), z, ez);
            check($sformatf("rnd_latency_d%0d", DIGITS[idx]), lat, W / DIGITS[idx]);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
